// File: rtl/uart_rx_fifo_ctrl_if.sv
// Signal bundle between the APB register block, the RX FIFO and the RX FIFO controller.
// The slave view belongs to the controller; the master view drives it.
interface uart_rx_fifo_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int SIZE_E = 6
);
    logic              FIFO_EN;
    logic [1:0]        TRIG_SEL;
    logic              CLEAR_REQ;
    logic              RX_WRITE;
    logic              CHAR_TICK;
    logic              RD_REQ;
    logic [WIDTH-1:0]  FIFO_Q;
    logic              FIFO_EMPTY;
    logic              FIFO_FULL;
    logic [SIZE_E-1:0] FIFO_USAGE;
    logic              FIFO_READ;
    logic              FIFO_CLEAR;
    logic [WIDTH-1:0]  RD_DATA;
    logic              RD_ACK;
    logic              RD_BUSY;
    logic              RDA_INT;
    logic              TIMEOUT_INT;

    modport slave (
        input  FIFO_EN, TRIG_SEL, CLEAR_REQ, RX_WRITE, CHAR_TICK, RD_REQ,
               FIFO_Q, FIFO_EMPTY, FIFO_FULL, FIFO_USAGE,
        output FIFO_READ, FIFO_CLEAR, RD_DATA, RD_ACK, RD_BUSY, RDA_INT, TIMEOUT_INT
    );

    modport master (
        output FIFO_EN, TRIG_SEL, CLEAR_REQ, RX_WRITE, CHAR_TICK, RD_REQ,
               FIFO_Q, FIFO_EMPTY, FIFO_FULL, FIFO_USAGE,
        input  FIFO_READ, FIFO_CLEAR, RD_DATA, RD_ACK, RD_BUSY, RDA_INT, TIMEOUT_INT
    );
endinterface

// File: rtl/uart_rx_fifo_ctrl.sv
// UART RX FIFO controller: paces CPU reads against the FIFO flag latency, issues CLEAR,
// and raises the 16550-style trigger-level and character-timeout interrupt conditions.
module uart_rx_fifo_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SIZE_E        = 6,
    parameter int TIMEOUT_CHARS = 4,
    parameter int LVL1          = 1,
    parameter int LVL2          = 16,
    parameter int LVL3          = 32,
    parameter int LVL4          = 56
) (
    input  logic               CLK,
    input  logic               RST,
    uart_rx_fifo_ctrl_if.slave bus
);
    localparam int              CW        = $clog2(TIMEOUT_CHARS) + 1;
    localparam logic [CW-1:0]   C_TIMEOUT = CW'(TIMEOUT_CHARS);
    localparam logic [SIZE_E:0] C_DEPTH   = (SIZE_E+1)'(2**SIZE_E);
    localparam logic [SIZE_E:0] C_LVL1    = (SIZE_E+1)'(LVL1);
    localparam logic [SIZE_E:0] C_LVL2    = (SIZE_E+1)'(LVL2);
    localparam logic [SIZE_E:0] C_LVL3    = (SIZE_E+1)'(LVL3);
    localparam logic [SIZE_E:0] C_LVL4    = (SIZE_E+1)'(LVL4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT1,
        S_WAIT2,
        S_CLRW
    } state_t;

    state_t           r_state;
    state_t           w_stateNext;
    logic             r_clrFirst;
    logic [WIDTH-1:0] r_rdData;
    logic             r_emptyAck;
    logic [CW-1:0]    r_toCnt;
    logic [CW-1:0]    w_toCntNext;
    logic             r_rdaInt;
    logic             r_toInt;
    logic             w_fifoRead;
    logic             w_fifoClear;
    logic             w_rdAck;
    logic             w_rdBusy;
    logic             w_readStart;
    logic [SIZE_E:0]  w_fillLevel;
    logic [SIZE_E:0]  w_trigLevel;
    logic             w_rdaCond;

    // r_clrFirst marks the first CLRW cycle, the one that carries the FIFO_CLEAR pulse.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_clrFirst <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_clrFirst <= bus.CLEAR_REQ;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        if (bus.CLEAR_REQ) begin
            w_stateNext = S_CLRW;
        end else begin
            unique case (r_state)
                S_IDLE:  w_stateNext = (bus.RD_REQ && !bus.FIFO_EMPTY) ? S_READ : S_IDLE;
                S_READ:  w_stateNext = S_WAIT1;
                S_WAIT1: w_stateNext = S_WAIT2;
                S_WAIT2: w_stateNext = S_IDLE;
                S_CLRW:  w_stateNext = r_clrFirst ? S_CLRW : S_IDLE;
                default: w_stateNext = S_IDLE;
            endcase
        end
    end

    // Strobes decode from registered state only, so reset cannot glitch READ or CLEAR.
    always_comb begin
        w_fifoRead  = (r_state == S_READ);
        w_fifoClear = (r_state == S_CLRW) && r_clrFirst;
        w_rdAck     = (r_state == S_READ) || r_emptyAck;
        w_rdBusy    = (r_state != S_IDLE);
    end

    assign w_readStart = (r_state == S_IDLE) && bus.RD_REQ && !bus.CLEAR_REQ;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rdData   <= '0;
            r_emptyAck <= 1'b0;
        end else begin
            r_emptyAck <= w_readStart && bus.FIFO_EMPTY;
            if (w_readStart) begin
                r_rdData <= bus.FIFO_EMPTY ? '0 : bus.FIFO_Q;
            end
        end
    end

    // USAGE wraps to zero at full, so FULL supplies the missing top bit of the fill level.
    always_comb begin
        w_fillLevel = bus.FIFO_FULL ? C_DEPTH : {1'b0, bus.FIFO_USAGE};
        unique case (bus.TRIG_SEL)
            2'b00:   w_trigLevel = C_LVL1;
            2'b01:   w_trigLevel = C_LVL2;
            2'b10:   w_trigLevel = C_LVL3;
            default: w_trigLevel = C_LVL4;
        endcase
        w_rdaCond = bus.FIFO_EN ? (w_fillLevel >= w_trigLevel) : !bus.FIFO_EMPTY;
    end

    always_comb begin
        w_toCntNext = r_toCnt;
        if (bus.RX_WRITE || w_fifoRead || w_fifoClear || bus.FIFO_EMPTY) begin
            w_toCntNext = '0;
        end else if (bus.CHAR_TICK && (r_toCnt != C_TIMEOUT)) begin
            w_toCntNext = r_toCnt + CW'(1);
        end
    end

    // Interrupts look at the next count so a reset event clears TIMEOUT_INT one cycle later.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_toCnt  <= '0;
            r_toInt  <= 1'b0;
            r_rdaInt <= 1'b0;
        end else begin
            r_toCnt  <= w_toCntNext;
            r_toInt  <= (w_toCntNext == C_TIMEOUT) && bus.FIFO_EN && !bus.FIFO_EMPTY;
            r_rdaInt <= (w_stateNext == S_CLRW) ? 1'b0 : w_rdaCond;
        end
    end

    assign bus.FIFO_READ   = w_fifoRead;
    assign bus.FIFO_CLEAR  = w_fifoClear;
    assign bus.RD_DATA     = r_rdData;
    assign bus.RD_ACK      = w_rdAck;
    assign bus.RD_BUSY     = w_rdBusy;
    assign bus.RDA_INT     = r_rdaInt;
    assign bus.TIMEOUT_INT = r_toInt;
endmodule

// File: tb/tb_uart_rx_fifo_ctrl.sv
// Directed bench for uart_rx_fifo_ctrl with a behavioural 64-entry RX FIFO behind it.
module tb_uart_rx_fifo_ctrl;
    localparam int WIDTH  = 8;
    localparam int SIZE_E = 6;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] wrData = 8'h00;
    int         vectors = 0;
    int         miscompares = 0;
    int         clrPulses = 0;
    int         ackPulses = 0;
    int         clrBase;
    int         ackBase;

    uart_rx_fifo_ctrl_if #(.WIDTH(WIDTH), .SIZE_E(SIZE_E)) bus ();

    uart_rx_fifo_ctrl #(
        .WIDTH(WIDTH), .SIZE_E(SIZE_E), .TIMEOUT_CHARS(4),
        .LVL1(1), .LVL2(16), .LVL3(32), .LVL4(56)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus.slave)
    );

    always #5 CLK = ~CLK;

    // Behavioural FIFO: registered pointers, Q shows the head entry.
    logic [7:0] fifoMem [64];
    logic [5:0] wrPtr;
    logic [5:0] rdPtr;
    logic [6:0] fifoCnt;
    logic       doWrite;
    logic       doRead;

    assign doWrite = bus.RX_WRITE && (fifoCnt != 7'd64);
    assign doRead  = bus.FIFO_READ && (fifoCnt != 7'd0);

    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
        end else if (bus.FIFO_CLEAR) begin
            wrPtr   <= '0;
            rdPtr   <= '0;
            fifoCnt <= '0;
        end else begin
            if (doWrite) begin
                fifoMem[wrPtr] <= wrData;
                wrPtr <= wrPtr + 6'd1;
            end
            if (doRead) rdPtr <= rdPtr + 6'd1;
            fifoCnt <= fifoCnt + 7'(doWrite) - 7'(doRead);
        end
    end

    assign bus.FIFO_Q     = fifoMem[rdPtr];
    assign bus.FIFO_EMPTY = (fifoCnt == 7'd0);
    assign bus.FIFO_FULL  = (fifoCnt == 7'd64);
    assign bus.FIFO_USAGE = fifoCnt[5:0];

    always @(posedge CLK) begin
        if (!RST) begin
            if (bus.FIFO_CLEAR) clrPulses <= clrPulses + 1;
            if (bus.RD_ACK)     ackPulses <= ackPulses + 1;
        end
    end

    function automatic logic [31:0] outVec();
        return {18'd0, bus.FIFO_READ, bus.FIFO_CLEAR, bus.RD_ACK, bus.RD_BUSY,
                bus.RDA_INT, bus.TIMEOUT_INT, bus.RD_DATA};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives one clock of inputs from a negedge and returns on the following negedge.
    task automatic applyStimulus(input logic rd, input logic clr, input logic wr,
                                 input logic [7:0] data, input logic tick);
        bus.RD_REQ    = rd;
        bus.CLEAR_REQ = clr;
        bus.RX_WRITE  = wr;
        wrData        = data;
        bus.CHAR_TICK = tick;
        @(negedge CLK);
        bus.RD_REQ    = 1'b0;
        bus.CLEAR_REQ = 1'b0;
        bus.RX_WRITE  = 1'b0;
        bus.CHAR_TICK = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        logic [7:0] readExp [3];
        readExp[0] = 8'hA1;
        readExp[1] = 8'hA2;
        readExp[2] = 8'hA3;
        bus.FIFO_EN   = 1'b1;
        bus.TRIG_SEL  = 2'b00;
        bus.RD_REQ    = 1'b0;
        bus.CLEAR_REQ = 1'b0;
        bus.RX_WRITE  = 1'b0;
        bus.CHAR_TICK = 1'b0;

        idle(3);
        checkOutput("reset_outputs", outVec(), 32'h0);
        RST = 1'b0;
        idle(1);

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b1, readExp[i], 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput($sformatf("read%0d_ack", i), {31'd0, bus.RD_ACK}, 32'd1);
            checkOutput($sformatf("read%0d_data", i), {24'd0, bus.RD_DATA}, {24'd0, readExp[i]});
            checkOutput($sformatf("read%0d_fifo_read", i), {31'd0, bus.FIFO_READ}, 32'd1);
            idle(1);
            checkOutput($sformatf("read%0d_read_drop", i), {30'd0, bus.FIFO_READ, bus.RD_ACK}, 32'd0);
            idle(2);
            checkOutput($sformatf("read%0d_idle", i), {31'd0, bus.RD_BUSY}, 32'd0);
        end

        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("empty_read", {29'd0, bus.RD_ACK, bus.FIFO_READ, bus.RD_BUSY}, 32'h4);
        checkOutput("empty_read_data", {24'd0, bus.RD_DATA}, 32'h0);
        idle(1);
        checkOutput("empty_ack_pulse", {31'd0, bus.RD_ACK}, 32'd0);

        bus.TRIG_SEL = 2'b01;
        for (int k = 0; k < 15; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        idle(1);
        checkOutput("rda_15_of_16", {31'd0, bus.RDA_INT}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h4F, 1'b0);
        idle(1);
        checkOutput("rda_16_of_16", {31'd0, bus.RDA_INT}, 32'd1);
        bus.TRIG_SEL = 2'b11;
        for (int k = 16; k < 55; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        idle(1);
        checkOutput("rda_55_of_56", {31'd0, bus.RDA_INT}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
        idle(1);
        checkOutput("rda_56_of_56", {31'd0, bus.RDA_INT}, 32'd1);
        for (int k = 56; k < 64; k++) applyStimulus(1'b0, 1'b0, 1'b1, 8'(8'h40 + k), 1'b0);
        idle(1);
        checkOutput("rda_full_wrap", {31'd0, bus.RDA_INT}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("full_read_data", {24'd0, bus.RD_DATA}, 32'h40);
        idle(3);
        checkOutput("rda_63_of_56", {31'd0, bus.RDA_INT}, 32'd1);

        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        idle(2);
        checkOutput("flush_done", {30'd0, bus.RD_BUSY, bus.RDA_INT}, 32'd0);

        bus.FIFO_EN = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB1, 1'b0);
        idle(1);
        checkOutput("rda_fifo_disabled", {31'd0, bus.RDA_INT}, 32'd1);
        bus.FIFO_EN  = 1'b1;
        bus.TRIG_SEL = 2'b00;
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB2, 1'b0);
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("timeout_tick%0d", t), {31'd0, bus.TIMEOUT_INT}, (t == 4) ? 32'd1 : 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("timeout_saturate", {31'd0, bus.TIMEOUT_INT}, 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB3, 1'b1);
        checkOutput("timeout_write_wins", {31'd0, bus.TIMEOUT_INT}, 32'd0);
        for (int t = 1; t <= 4; t++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput($sformatf("timeout_retick%0d", t), {31'd0, bus.TIMEOUT_INT}, (t == 4) ? 32'd1 : 32'd0);
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB4, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hB5, 1'b0);
        clrBase = clrPulses;
        ackBase = ackPulses;
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("clear_pulse", {29'd0, bus.FIFO_CLEAR, bus.RD_ACK, bus.FIFO_READ}, 32'h4);
        checkOutput("clear_rda_forced", {31'd0, bus.RDA_INT}, 32'd0);
        idle(2);
        checkOutput("clear_pulse_count", 32'(clrPulses - clrBase), 32'd1);
        checkOutput("clear_no_ack", 32'(ackPulses - ackBase), 32'd0);
        checkOutput("clear_irqs_idle", {29'd0, bus.RD_BUSY, bus.RDA_INT, bus.TIMEOUT_INT}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'hC7, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("post_clear_read", {23'd0, bus.RD_ACK, bus.RD_DATA}, 32'h1C7);
        idle(3);

        applyStimulus(1'b0, 1'b0, 1'b1, 8'hD5, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        idle(1);
        checkOutput("wait1_busy", {31'd0, bus.RD_BUSY}, 32'd1);
        RST = 1'b1;
        #1;
        checkOutput("midop_reset", outVec(), 32'h0);
        idle(1);
        RST = 1'b0;
        idle(1);
        checkOutput("post_reset_idle", outVec(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo_ctrl.md
Name: uart_rx_fifo_ctrl

Overview:
Controller for the UART receive FIFO (slib_fifo instance, registered Q, USAGE, EMPTY/FULL flags). It sequences CPU reads against the FIFO's two-cycle pointer-to-flag latency and issues CLEAR. It also generates the 16550-style "received data available" (trigger-level) and "character timeout" interrupt conditions. It sits between the APB register block and the RX FIFO.

Parameters:
WIDTH, 8, FIFO data width
SIZE_E, 6, FIFO address width; depth = 2**SIZE_E; matches FIFO instance
TIMEOUT_CHARS, 4, character times without activity before timeout fires
LVL1, 1, trigger level for TRIG_SEL=2'b00
LVL2, 16, trigger level for TRIG_SEL=2'b01
LVL3, 32, trigger level for TRIG_SEL=2'b10
LVL4, 56, trigger level for TRIG_SEL=2'b11

Ports:
CLK  in  1  clock
RST  in  1  reset; asynchronous, active-high
FIFO_EN  in  1  FCR FIFO enable; 0 forces trigger level 1
TRIG_SEL  in  2  FCR trigger level select
CLEAR_REQ  in  1  one-cycle pulse: flush RX FIFO
RX_WRITE  in  1  pulse: receiver writes a character this cycle (same signal as FIFO WRITE)
CHAR_TICK  in  1  one-cycle pulse per character time
RD_REQ  in  1  CPU read request (level; sampled only in IDLE)
FIFO_Q  in  WIDTH  FIFO Q
FIFO_EMPTY  in  1  FIFO EMPTY
FIFO_FULL  in  1  FIFO FULL
FIFO_USAGE  in  SIZE_E  FIFO USAGE
FIFO_READ  out  1  to FIFO READ
FIFO_CLEAR  out  1  to FIFO CLEAR
RD_DATA  out  WIDTH  data returned to CPU
RD_ACK  out  1  one-cycle pulse: RD_DATA valid
RD_BUSY  out  1  high in any non-IDLE state
RDA_INT  out  1  trigger-level condition
TIMEOUT_INT  out  1  character-timeout condition

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0.
- Fill level L = FIFO_FULL ? 2**SIZE_E : FIFO_USAGE (width SIZE_E+1). The FULL term covers the wrap of USAGE to 0 at full.
- Read FSM states: IDLE, READ, WAIT1, WAIT2, CLRW.
  - IDLE and RD_REQ=1:
    - FIFO_EMPTY=0: register RD_DATA<=FIFO_Q; assert FIFO_READ for exactly one cycle; go to READ.
    - FIFO_EMPTY=1: RD_DATA<=0, no FIFO_READ; RD_ACK pulses next cycle; stay IDLE.
  - READ: RD_ACK=1 for one cycle; go to WAIT1.
  - WAIT1 -> WAIT2 -> IDLE. These states cover the 2-cycle FIFO latency before Q/EMPTY reflect the new head; RD_REQ is ignored here.
  - Read latency: 1 cycle req->ack. Back-to-back reads are accepted every 4 cycles.
- Clear:
  - CLEAR_REQ in any state: FIFO_CLEAR=1 the next cycle for one cycle; go to CLRW.
  - Any in-flight READ/WAIT is aborted; RD_ACK is suppressed if not yet issued.
  - CLRW lasts 2 cycles, then IDLE.
  - CLEAR_REQ has priority over RD_REQ in the same cycle.
- RDA_INT (registered, 1-cycle lag):
  - = (L >= level) when FIFO_EN=1; level selected by TRIG_SEL.
  - = !FIFO_EMPTY when FIFO_EN=0.
  - Forced 0 during CLRW.
- Timeout counter (width clog2(TIMEOUT_CHARS)+1):
  - Resets to 0 on RX_WRITE, on FIFO_READ, on FIFO_CLEAR, or when FIFO_EMPTY=1.
  - Otherwise increments on CHAR_TICK; saturates at TIMEOUT_CHARS.
  - TIMEOUT_INT = (count==TIMEOUT_CHARS) && FIFO_EN && !FIFO_EMPTY; registered.
  - TIMEOUT_INT clears the cycle after any counter reset event.
  - RX_WRITE coincident with CHAR_TICK: reset wins.
- RX_WRITE coincident with a read: no interaction beyond the timeout reset. The controller does not gate FIFO writes.
- RST asserted mid-operation: immediate return to reset values; no FIFO_READ/FIFO_CLEAR glitch.

Test Plan:
- Reset, then write 3 bytes 0xA1,0xA2,0xA3 via FIFO; RD_REQ three times -> RD_ACK with RD_DATA 0xA1,0xA2,0xA3. Each FIFO_READ is exactly 1 cycle; requests are spaced 4 cycles.
- Empty FIFO, RD_REQ=1 -> RD_ACK with RD_DATA=0x00; FIFO_READ never asserts.
- FIFO_EN=1, TRIG_SEL=01: write 15 bytes -> RDA_INT=0; 16th byte -> RDA_INT=1. Fill to 64 (USAGE wraps to 0, FULL=1) with TRIG_SEL=11 -> RDA_INT stays 1. One read -> RDA_INT still 1 (63>=56).
- 2 bytes in FIFO, no activity, 4 CHAR_TICKs -> TIMEOUT_INT=1 after the 4th. An RX_WRITE then clears it; 3 ticks -> still 0.
- CLEAR_REQ in the same cycle as RD_REQ with 5 bytes -> one FIFO_CLEAR pulse, no RD_ACK, EMPTY within 2 cycles, RDA_INT/TIMEOUT_INT=0. RD_REQ is honoured again after CLRW.
- Assert RST during WAIT1 -> all outputs 0 immediately; state IDLE on release.
